avr_fetch: RTL and testbench
============================

# avr_fetch

Instruction fetch unit for the AVR core: reads 16-bit words from the synchronous program ROM and feeds the core's `instr` input. It replaces bench-driven instruction stimulus with a real supplier that follows `p_addr`-style redirects. A prefetch FIFO holds fetched words. The unit detects two-word opcodes (LDS, STS, JMP, CALL) and presents both words together. It sits between program memory and `avr_cpu`.

## Interface
- `PC_W`, 16: word-address width of program memory.
- `DEPTH`, 4: prefetch FIFO entries, minimum 2.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `pm_rd` out 1: read strobe to program ROM.
- `pm_addr` out PC_W: word address for the read.
- `pm_data` in 16: ROM data, valid exactly one cycle after `pm_rd`.
- `instr` out 16: first (or only) word of the head instruction.
- `instr_ext` out 16: second word of a two-word instruction; 0 otherwise.
- `instr_two` out 1: head instruction is two-word.
- `instr_pc` out PC_W: word address of the head instruction.
- `instr_valid` out 1: head instruction is complete and presentable.
- `instr_ready` in 1: core consumes the head this cycle.
- `redirect` in 1: branch, jump or return; flush and refetch.
- `redirect_pc` in PC_W: new word address when `redirect` is high.

## Operation
- Fetch pointer `fpc` resets to 0. `inflight` is a 1-bit flag marking a ROM read whose data returns next cycle.
- Issue rule: `pm_rd`=1 when `count + inflight - pops_this_cycle < DEPTH`, or when `redirect`=1 (FIFO is flushed).
- `pm_addr` = `redirect ? redirect_pc : fpc` (combinational mux).
- On issue, `fpc` ← `pm_addr + 1`, mod 2^PC_W. Wrap from all-ones to 0 is legal.
- Return: when `inflight`=1 and the read was not killed, `pm_data` is pushed at the next edge.
- Kill: `redirect` kills any read issued in the previous cycle, so its data is discarded. It also empties the FIFO, and `instr_pc` ← `redirect_pc`.
- Two-word detect applies to the head word only. Two-word means `w[15:10]`=100100 with `w[3:0]`=0000 (LDS/STS), or `w[15:9]`=1001010 with `w[3:1]`=110 or 111 (JMP/CALL).
- `instr_valid` = `count≥1` for a one-word head; `count≥2` for a two-word head.
- On `instr_valid & instr_ready & !redirect`, pop 1 or 2 entries; `instr_pc` advances by 1 or 2, mod 2^PC_W.
- A push and a pop in the same cycle are allowed. The FIFO never overflows because the issue rule reserves space.
- When `redirect` and `instr_ready` are both high, `redirect` wins and the consume is ignored.
- Outputs when `instr_valid`=0: `instr` and `instr_ext` show the current head contents. They are don't-care, and the core ignores them.

## Timing
- Reset values: `pm_rd`=0, `pm_addr`=0, `instr`=0, `instr_ext`=0, `instr_two`=0, `instr_pc`=0, `instr_valid`=0. Also `inflight`=0 and `count`=0.
- The first `pm_rd` is issued in the first cycle after `RST_N` deasserts.
- ROM latency: address in cycle N, data pushed at the end of N+1.
- Fetch latency: read issued in N gives `instr_valid` in N+2 for a one-word instruction and N+3 for a two-word instruction.
- Throughput: one word per cycle sustained once the FIFO is primed.
- Redirect penalty: redirect in cycle N gives the first valid instruction in N+2.
- Reset mid-operation clears all state asynchronously. Any `pm_data` returned after release is ignored because `inflight`=0.

## Structure
- Shared package `avr_pkg`:
  - `PC_W` default.
  - LDS/STS/JMP/CALL match masks and values.
  - Function `is_two_word(logic [15:0])`, which `avr_cpu`'s decoder also uses.
- Sub-module `avr_fetch_fifo`: synchronous FIFO, DEPTH×16.
  - One push port.
  - Pop of 0, 1 or 2 entries.
  - Exposes `count`, `head0` and `head1`.
  - Synchronous flush; asynchronous active-low reset.
- Top-level `avr_fetch` holds `fpc`, `inflight`/kill, `instr_pc`, and the issue and valid logic.

## Test plan
- Straight line:
  - Stimulus: ROM[0..3] = 0x0000, 0x50A1, 0x50A2, 0x50A0; `instr_ready`=1.
  - Response: `instr_valid` in cycle 2 after reset; then one instruction per cycle with `instr_pc` = 0, 1, 2, 3.
- Two-word:
  - Stimulus: ROM[4]=0x940C (JMP), ROM[5]=0x0010.
  - Response: a single instruction with `instr`=0x940C, `instr_ext`=0x0010, `instr_two`=1, `instr_pc`=4; the next `instr_pc`=6.
- Backpressure:
  - Stimulus: hold `instr_ready`=0 for 8 cycles.
  - Response: `pm_rd` stops after DEPTH words are buffered or in flight; no word is lost or duplicated after release.
- Redirect with in-flight read:
  - Stimulus: `redirect`=1 with `redirect_pc`=0x0010 while a read is in flight.
  - Response: stale data is discarded; `pm_addr`=0x0010 in the same cycle; the next valid `instr_pc`=0x0010 two cycles later.
- Wrap and simultaneous events:
  - Stimulus: `redirect_pc`=0xFFFF, then `redirect` and `instr_ready` asserted in the same cycle.
  - Response: `fpc` wraps to 0x0000; the redirect wins and the consume is ignored.
- Reset mid-fetch:
  - Stimulus: assert `RST_N`=0 asynchronously mid-cycle with FIFO count 3.
  - Response: all outputs go to 0 immediately; fetch resumes at address 0.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared AVR definitions: program-memory width and two-word opcode detection
// used by both the fetch unit and the core decoder.
package avr_pkg;

  localparam int PC_W_DEF = 16;

  typedef logic [15:0] word_t;

  // LDS/STS: 1001 00xd dddd 0000 ; JMP/CALL: 1001 010k kkkk 11xk
  localparam word_t LDS_STS_MASK  = 16'hFC0F;
  localparam word_t LDS_STS_VAL   = 16'h9000;
  localparam word_t JMP_CALL_MASK = 16'hFE0C;
  localparam word_t JMP_CALL_VAL  = 16'h940C;

  function automatic logic is_two_word(input word_t w);
    return ((w & LDS_STS_MASK) == LDS_STS_VAL) ||
           ((w & JMP_CALL_MASK) == JMP_CALL_VAL);
  endfunction

endpackage

// File: rtl/avr_fetch_fifo.sv
// Prefetch FIFO: one push per cycle, pop of 0/1/2 entries, exposes the two
// head entries so a two-word instruction can be presented as a unit.
module avr_fetch_fifo
  import avr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  word_t                        i_push_data,
  input  logic [1:0]                   i_pop_n,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output word_t                        o_head0,
  output word_t                        o_head1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [CW-1:0]  r_count;

  // Pointer arithmetic modulo DEPTH so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return AW'(s);
  endfunction

  assign o_count = r_count;
  assign o_head0 = r_mem[r_rd];
  assign o_head1 = r_mem[ptr_add(r_rd, 2'd1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= ptr_add(r_wr, 2'd1);
      end
      r_rd    <= ptr_add(r_rd, i_pop_n);
      r_count <= r_count + CW'(i_push) - CW'(i_pop_n);
    end
  end

endmodule

// File: rtl/avr_fetch.sv
// Instruction fetch unit: issues program-ROM reads, buffers returned words and
// presents one- or two-word instructions to the core, following redirects.
module avr_fetch
  import avr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            pm_rd,
  output logic [PC_W-1:0] pm_addr,
  input  logic [15:0]     pm_data,
  output logic [15:0]     instr,
  output logic [15:0]     instr_ext,
  output logic            instr_two,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = CW + 1;

  logic [PC_W-1:0] r_fpc;
  logic [PC_W-1:0] r_instr_pc;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  word_t           w_head0;
  word_t           w_head1;
  logic            w_push;
  logic            w_consume;
  logic [1:0]      w_pop_n;
  logic [LW-1:0]   w_level;
  logic            w_issue;

  avr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (pm_data),
    .i_pop_n     (w_pop_n),
    .o_count     (w_count),
    .o_head0     (w_head0),
    .o_head1     (w_head1)
  );

  assign instr_two   = is_two_word(w_head0);
  assign instr_valid = instr_two ? (w_count >= CW'(2)) : (w_count != '0);
  assign instr       = w_head0;
  assign instr_ext   = instr_two ? w_head1 : 16'h0000;
  assign instr_pc    = r_instr_pc;

  // A redirect flushes the FIFO and kills the read issued last cycle.
  assign w_push    = r_inflight & ~redirect;
  assign w_consume = instr_valid & instr_ready & ~redirect;
  assign w_pop_n   = w_consume ? (instr_two ? 2'd2 : 2'd1) : 2'd0;

  // Occupancy after this edge; a new read needs one free slot beyond it.
  assign w_level = LW'(w_count) + LW'(r_inflight) - LW'(w_pop_n);

  // Gated by RST_N so the ROM port is idle while reset is held.
  assign w_issue = RST_N & (redirect | (w_level < LW'(DEPTH)));
  assign pm_rd   = w_issue;
  assign pm_addr = RST_N ? (redirect ? redirect_pc : r_fpc) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fpc      <= '0;
      r_inflight <= 1'b0;
      r_instr_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_fpc <= pm_addr + PC_W'(1);
      if (redirect)
        r_instr_pc <= redirect_pc;
      else if (w_consume)
        r_instr_pc <= r_instr_pc + PC_W'(w_pop_n);
    end
  end

endmodule

// File: tb/tb_avr_fetch.sv
// Bench for avr_fetch: directed scenarios plus random ready/redirect traffic,
// checked against an in-order program-stream model over a bench-owned ROM.
module tb_avr_fetch;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST_N;
  logic        pm_rd;
  logic [15:0] pm_addr;
  logic [15:0] pm_data;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic        instr_two;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  avr_fetch #(.PC_W(16), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pm_rd       (pm_rd),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_two   (instr_two),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] rom [0:65535];
  initial pm_data = 16'hDEAD;
  always @(posedge CLK) if (pm_rd) pm_data <= rom[pm_addr];

  int          n_pass;
  int          n_total;
  logic [15:0] m_pc;
  logic [15:0] last_rpc;
  int          n_issued;
  int          n_consumed;
  int          age;
  int          streak;

  function automatic bit ref_two(input logic [15:0] w);
    return (w[15:10] == 6'b100100 && w[3:0] == 4'b0000) ||
           (w[15:9] == 7'b1001010 && (w[3:1] == 3'b110 || w[3:1] == 3'b111));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check the
  // presented head against the expected program stream.
  task automatic cyc(input logic rdy, input logic rd, input logic [15:0] rpc);
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] nxt;
    bit          t;
    @(negedge CLK);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    if (rd) begin
      chk("redir_rd", pm_rd, 1);
      chk("redir_addr", pm_addr, rpc);
      m_pc       = rpc;
      last_rpc   = rpc;
      n_issued   = 1;
      n_consumed = 0;
      age        = 0;
      streak     = 0;
    end else begin
      if (pm_rd) n_issued++;
      if (age < 100) age++;
      if (age == 2) chk("redir_latency", instr_valid, !ref_two(rom[last_rpc]));
      if (instr_valid && rdy) begin
        nxt = m_pc + 16'd1;
        w0  = rom[m_pc];
        w1  = rom[nxt];
        t   = ref_two(w0);
        chk("stream_pc", instr_pc, m_pc);
        chk("stream_instr", instr, w0);
        chk("stream_two", instr_two, t);
        chk("stream_ext", instr_ext, t ? w1 : 16'h0000);
        m_pc       = m_pc + (t ? 16'd2 : 16'd1);
        n_consumed = n_consumed + (t ? 2 : 1);
        streak     = 0;
      end else if (rdy) begin
        streak++;
      end else begin
        streak = 0;
      end
      chk("stall_bound", 32'(streak <= 3), 1);
    end
  endtask

  task automatic release_rst();
    @(negedge CLK);
    RST_N       = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    #1;
    chk("release_rd", pm_rd, 1);
    chk("release_addr", pm_addr, 16'h0000);
    m_pc       = 16'h0000;
    last_rpc   = 16'h0000;
    n_issued   = 1;
    n_consumed = 0;
    age        = 0;
    streak     = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pm_rd"}, pm_rd, 0);
    chk({tag, "_pm_addr"}, pm_addr, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_ext"}, instr_ext, 0);
    chk({tag, "_instr_two"}, instr_two, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_pc = 0; last_rpc = 0; n_issued = 0; n_consumed = 0; age = 100; streak = 0;
    RST_N = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

    for (int a = 0; a < 65536; a++) rom[a] = 16'h1000 | (16'(a) & 16'h0FFF);
    rom[0] = 16'h0000; rom[1] = 16'h50A1; rom[2] = 16'h50A2; rom[3] = 16'h50A0;
    rom[4] = 16'h940C; rom[5] = 16'h0010;
    rom[16'hFFFF] = 16'h940E;

    repeat (2) @(negedge CLK);
    #1;
    chk_all_zero("reset");

    // Straight line and two-word
    release_rst();
    cyc(1, 0, 0); chk("c1_valid", instr_valid, 0);
    cyc(1, 0, 0); chk("c2_valid", instr_valid, 1); chk("c2_pc", instr_pc, 16'd0); chk("c2_instr", instr, 16'h0000);
    cyc(1, 0, 0); chk("c3_pc", instr_pc, 16'd1); chk("c3_instr", instr, 16'h50A1);
    cyc(1, 0, 0); chk("c4_pc", instr_pc, 16'd2); chk("c4_instr", instr, 16'h50A2);
    cyc(1, 0, 0); chk("c5_pc", instr_pc, 16'd3); chk("c5_instr", instr, 16'h50A0);
    cyc(1, 0, 0); chk("c6_valid", instr_valid, 0); chk("c6_two", instr_two, 1);
    cyc(1, 0, 0); chk("jmp_valid", instr_valid, 1); chk("jmp_pc", instr_pc, 16'd4);
    chk("jmp_instr", instr, 16'h940C); chk("jmp_ext", instr_ext, 16'h0010); chk("jmp_two", instr_two, 1);
    cyc(1, 0, 0); chk("after_jmp_pc", instr_pc, 16'd6); chk("after_jmp_valid", instr_valid, 1);

    // Backpressure
    repeat (8) cyc(0, 0, 0);
    chk("bp_rd_stopped", pm_rd, 0);
    chk("bp_outstanding", n_issued - n_consumed, DEPTH);
    chk("bp_hold_pc", instr_pc, 16'd7);
    chk("bp_hold_valid", instr_valid, 1);
    cyc(1, 0, 0); chk("bp_resume_pc", instr_pc, 16'd7);
    repeat (3) cyc(1, 0, 0);

    // Redirect while a read is in flight
    cyc(1, 1, 16'h0010);
    cyc(1, 0, 0); chk("rd_flush_valid", instr_valid, 0);
    cyc(1, 0, 0); chk("rd_valid", instr_valid, 1); chk("rd_pc", instr_pc, 16'h0010); chk("rd_instr", instr, 16'h1010);

    // Wrap with simultaneous redirect and consume
    chk("sim_head_valid", instr_valid, 1);
    cyc(1, 1, 16'hFFFF);
    cyc(1, 0, 0); chk("wrap_rd", pm_rd, 1); chk("wrap_fpc", pm_addr, 16'h0000); chk("wrap_valid0", instr_valid, 0);
    cyc(1, 0, 0); chk("wrap_valid1", instr_valid, 0); chk("wrap_two_pending", instr_two, 1);
    cyc(1, 0, 0); chk("wrap_valid", instr_valid, 1); chk("wrap_pc", instr_pc, 16'hFFFF);
    chk("wrap_instr", instr, 16'h940E); chk("wrap_ext", instr_ext, 16'h0000); chk("wrap_two", instr_two, 1);
    cyc(1, 0, 0); chk("wrap_next_pc", instr_pc, 16'h0001); chk("wrap_next_instr", instr, 16'h50A1);

    // Reset mid-fetch with three buffered words
    cyc(0, 1, 16'h0010);
    repeat (4) cyc(0, 0, 0);
    chk("pre_reset_valid", instr_valid, 1);
    chk("pre_reset_pc", instr_pc, 16'h0010);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("midrst");
    release_rst();
    cyc(1, 0, 0); chk("rst_c1_valid", instr_valid, 0);
    cyc(1, 0, 0); chk("rst_c2_valid", instr_valid, 1); chk("rst_c2_pc", instr_pc, 16'd0);

    // Random traffic over a random program
    @(negedge CLK);
    RST_N = 1'b0;
    for (int a = 0; a < 65536; a++) begin
      case ($urandom_range(0, 7))
        0:       rom[a] = 16'h940C | (16'($urandom) & 16'h01F3);
        1:       rom[a] = 16'h9000 | (16'($urandom) & 16'h03F0);
        default: rom[a] = 16'($urandom);
      endcase
    end
    release_rst();
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rd;
      logic [15:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
      cyc(rdy, rd, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
